// File: rtl/agp32_mem_pkg.sv
// Shared types and constants for the agp32 memory-side controller.
package agp32_mem_pkg;

  // Processor command encoding; values 5..7 are illegal.
  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_FETCH     = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_INTERRUPT = 3'd4
  } cmd_e;

  // Sticky error codes reported on the error port.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_RANGE   = 2'd2
  } err_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_RD_WAIT    = 3'd2,
    ST_RD_CAP     = 3'd3,
    ST_WR         = 3'd4,
    ST_FETCH_WAIT = 3'd5,
    ST_FETCH_CAP  = 3'd6,
    ST_ERR        = 3'd7
  } state_e;

  // Instruction the pipeline sees before the first real fetch.
  localparam logic [31:0] AGP32_NOP_INSTR = 32'd63;

endpackage

// File: rtl/agp32_mem_ctrl.sv
// Memory-side controller for the agp32 pipeline. It serves FETCH, INTERRUPT,
// READ and WRITE commands against a single-port synchronous RAM with a
// 1-cycle read latency. Every command finishes with a refetch at the current
// PC, so inst_rdata stays coherent with self-modifying stores.
module agp32_mem_ctrl
  import agp32_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        command,
  input  logic [31:0]       PC,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_wstrb,
  output logic              ready,
  output logic [31:0]       data_rdata,
  output logic [31:0]       inst_rdata,
  output logic              mem_start_ready,
  output logic [1:0]        error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              msr_q, msr_d;
  err_e              error_q, error_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic [31:0]       inst_rdata_q, inst_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  // Word addresses derived from the byte addresses; the low two bits are
  // ignored because byte placement is handled upstream through the strobes.
  logic [ADDR_W-1:0] pc_word;
  logic [ADDR_W-1:0] data_word;
  logic [31:0]       data_addr_hi;
  logic              data_out_of_range;

  assign pc_word           = PC[ADDR_W+1:2];
  assign data_word         = data_addr[ADDR_W+1:2];
  assign data_addr_hi      = data_addr >> (ADDR_W + 2);
  assign data_out_of_range = |data_addr_hi;

  // PC bits above the RAM window and the byte offsets play no part.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, PC[31:ADDR_W+2], PC[1:0], data_addr[1:0]};

  // Next-state and next-output logic for the controller FSM and init counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    msr_d        = msr_q;
    error_d      = error_q;
    data_rdata_d = data_rdata_q;
    inst_rdata_d = inst_rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = ram_we_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          msr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (ready_q && (command != CMD_NOP)) begin
          ready_d = 1'b0;
          case (command)
            CMD_FETCH, CMD_INTERRUPT: begin
              ram_addr_d = pc_word;
              state_d    = ST_FETCH_WAIT;
            end
            CMD_READ: begin
              if (data_out_of_range) begin
                error_d = ERR_RANGE;
                state_d = ST_ERR;
              end else begin
                ram_addr_d = data_word;
                state_d    = ST_RD_WAIT;
              end
            end
            CMD_WRITE: begin
              if (data_out_of_range) begin
                error_d = ERR_RANGE;
                state_d = ST_ERR;
              end else begin
                ram_addr_d  = data_word;
                ram_we_d    = data_wstrb;
                ram_wdata_d = data_wdata;
                state_d     = ST_WR;
              end
            end
            default: begin
              error_d = ERR_ILLEGAL;
              state_d = ST_ERR;
            end
          endcase
        end
      end

      // RAM samples the read address on this edge.
      ST_RD_WAIT: state_d = ST_RD_CAP;

      // Read data is on ram_rdata; capture it and issue the PC refetch.
      ST_RD_CAP: begin
        data_rdata_d = ram_rdata;
        ram_addr_d   = pc_word;
        state_d      = ST_FETCH_WAIT;
      end

      // RAM performs the write on this edge; then refetch at PC.
      ST_WR: begin
        ram_we_d   = 4'b0000;
        ram_addr_d = pc_word;
        state_d    = ST_FETCH_WAIT;
      end

      ST_FETCH_WAIT: state_d = ST_FETCH_CAP;

      ST_FETCH_CAP: begin
        inst_rdata_d = ram_rdata;
        ready_d      = 1'b1;
        state_d      = ST_IDLE;
      end

      // Terminal state: only reset leaves it.
      ST_ERR: begin
        ready_d  = 1'b0;
        ram_we_d = 4'b0000;
      end

      default: state_d = ST_ERR;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously so
  // an in-flight write enable drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      msr_q        <= 1'b0;
      error_q      <= ERR_NONE;
      data_rdata_q <= 32'd0;
      inst_rdata_q <= AGP32_NOP_INSTR;
      ram_addr_q   <= '0;
      ram_we_q     <= 4'b0000;
      ram_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      msr_q        <= msr_d;
      error_q      <= error_d;
      data_rdata_q <= data_rdata_d;
      inst_rdata_q <= inst_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign ready           = ready_q;
  assign mem_start_ready = msr_q;
  assign error           = error_q;
  assign data_rdata      = data_rdata_q;
  assign inst_rdata      = inst_rdata_q;
  assign ram_addr        = ram_addr_q;
  assign ram_we          = ram_we_q;
  assign ram_wdata       = ram_wdata_q;

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Directed bench for agp32_mem_ctrl with a behavioural single-port RAM.
module tb_agp32_mem_ctrl;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        command = 3'd0;
  logic [31:0]       PC = 32'd0;
  logic [31:0]       data_addr = 32'd0;
  logic [31:0]       data_wdata = 32'd0;
  logic [3:0]        data_wstrb = 4'd0;
  logic              ready;
  logic [31:0]       data_rdata;
  logic [31:0]       inst_rdata;
  logic              mem_start_ready;
  logic [1:0]        error;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  agp32_mem_ctrl #(.ADDR_W(ADDR_W), .INIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .command(command), .PC(PC),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .ready(ready), .data_rdata(data_rdata), .inst_rdata(inst_rdata),
    .mem_start_ready(mem_start_ready), .error(error),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: sync single-port, byte writes, 1-cycle read, plus a
  // bench-side preload port.
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [31:0]       bd_data = 32'd0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drive a command at a negedge; returns at the negedge just after E0.
  task automatic issue(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input bit hold);
    command = c; data_addr = a; data_wdata = wd; data_wstrb = ws;
    @(negedge clk);
    if (!hold) command = 3'd0;
  endtask

  // Counts samples with ready low, starting with the one after E0.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    // Preload while held in reset.
    preload(16'd5, 32'hDEADBEEF);
    preload(16'd2, 32'h12345678);

    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_msr", {31'd0, mem_start_ready}, 32'd0);
    check("rst_inst", inst_rdata, 32'd63);
    check("rst_err", {30'd0, error}, 32'd0);
    rst = 1'b0;

    // INIT: three edges still not ready, fourth brings ready.
    repeat (3) @(negedge clk);
    check("init_3_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("init_4_ready", {31'd0, ready}, 32'd1);
    check("init_4_msr", {31'd0, mem_start_ready}, 32'd1);
    check("init_inst", inst_rdata, 32'd63);

    // FETCH at PC=0x14 -> word 5.
    PC = 32'h14;
    issue(3'd1, 32'd0, 32'd0, 4'd0, 1'b0);
    wait_ready(n);
    check("fetch_low", n, 32'd2);
    check("fetch_inst", inst_rdata, 32'hDEADBEEF);

    // READ word 2 via byte addr 0x0B; PC changed at E0 to 0x08 must be fetched.
    issue(3'd2, 32'h0000_000B, 32'd0, 4'd0, 1'b0);
    PC = 32'h08;
    wait_ready(n);
    check("read_low", n, 32'd4);
    check("read_data", data_rdata, 32'h12345678);
    check("read_refetch_pc", inst_rdata, 32'h12345678);
    PC = 32'h14;

    // INTERRUPT refetches at PC like FETCH.
    issue(3'd4, 32'd0, 32'd0, 4'd0, 1'b0);
    wait_ready(n);
    check("irq_low", n, 32'd2);
    check("irq_inst", inst_rdata, 32'hDEADBEEF);

    // Self-modifying store to the word at PC.
    preload(16'd5, 32'h0);
    issue(3'd3, 32'h14, 32'h0000AB00, 4'b0010, 1'b0);
    check("wr_we_e0", {28'd0, ram_we}, 32'h2);
    @(negedge clk);
    check("wr_we_e1", {28'd0, ram_we}, 32'h0);
    n = 0;
    wait_ready(n);
    check("wr_low", n + 1, 32'd3);
    check("wr_mem", mem[5], 32'h0000AB00);
    check("wr_inst", inst_rdata, 32'h0000AB00);

    // Zero strobes write nothing but still refetch.
    issue(3'd3, 32'h14, 32'hFFFFFFFF, 4'b0000, 1'b0);
    wait_ready(n);
    check("wr0_low", n, 32'd3);
    check("wr0_mem", mem[5], 32'h0000AB00);

    // Held command: re-accepted one edge after ready returns.
    issue(3'd1, 32'd0, 32'd0, 4'd0, 1'b1);
    wait_ready(n);
    check("hold_ready_up", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check("hold_reaccept", {31'd0, ready}, 32'd0);
    command = 3'd0;
    wait_ready(n);
    check("hold_low", n, 32'd2);

    // Out-of-range READ -> sticky error 2, no RAM write, never ready.
    issue(3'd2, 32'h0004_0000, 32'd0, 4'd0, 1'b0);
    check("range_err", {30'd0, error}, 32'd2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready || ram_we != 4'd0) n++;
      @(negedge clk);
    end
    check("range_stuck", n, 32'd0);
    check("range_err_sticky", {30'd0, error}, 32'd2);

    // Asynchronous reset clears outputs at once.
    #2 rst = 1'b1;
    #1;
    check("arst_err", {30'd0, error}, 32'd0);
    check("arst_inst", inst_rdata, 32'd63);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("reinit_ready", {31'd0, ready}, 32'd1);

    // Illegal command -> error 1.
    issue(3'd6, 32'd0, 32'd0, 4'd0, 1'b0);
    check("illegal_err", {30'd0, error}, 32'd1);
    check("illegal_ready", {31'd0, ready}, 32'd0);

    // Reset in WR before the write edge: RAM keeps its old value.
    do_reset();
    repeat (4) @(negedge clk);
    issue(3'd3, 32'h14, 32'h11111111, 4'b1111, 1'b0);
    check("wrrst_we_set", {28'd0, ram_we}, 32'hF);
    rst = 1'b1;
    #1;
    check("wrrst_we_clr", {28'd0, ram_we}, 32'h0);
    @(negedge clk);
    check("wrrst_mem", mem[5], 32'h0000AB00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("wrrst_init_3", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("wrrst_init_4", {31'd0, mem_start_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
